// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet stream widths, beat layout, RX write-FSM states
package eth_pkg;
  localparam int ETH_DATA_W = 64;
  localparam int ETH_KEEP_W = 8;
  typedef enum logic [1:0] {WR_SYNC, WR_PASS, WR_DROP} wr_state_t;
  typedef struct packed {
    logic                  last;
    logic [ETH_KEEP_W-1:0] keep;
    logic [ETH_DATA_W-1:0] data;
  } beat_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v + 32'(v != '1);
  endfunction
endpackage

// File: rtl/eth_sdp_ram.sv
// eth_sdp_ram: simple dual-port RAM, one write port and one registered read port
module eth_sdp_ram #(
  parameter int W     = 73,
  parameter int DEPTH = 512
) (
  input  logic                     clk156,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk156) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/eth_rx_drop_fifo.sv
// eth_rx_drop_fifo: store-and-forward RX frame FIFO dropping bad or overflowing frames
module eth_rx_drop_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                    clk156,
  input  logic                    sys_rst_n,
  input  logic                    s_rx_tvalid,
  input  logic [ETH_DATA_W-1:0]   s_rx_tdata,
  input  logic [ETH_KEEP_W-1:0]   s_rx_tkeep,
  input  logic                    s_rx_tlast,
  input  logic                    s_rx_tuser,
  output logic                    m_rx_tvalid,
  input  logic                    m_rx_tready,
  output logic [ETH_DATA_W-1:0]   m_rx_tdata,
  output logic [ETH_KEEP_W-1:0]   m_rx_tkeep,
  output logic                    m_rx_tlast,
  output logic [31:0]             drop_err_cnt,
  output logic [31:0]             drop_ovf_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  wr_state_t   wr_state;
  logic [AW:0] wr_cur, wr_commit, rd_ptr, used;
  logic        full, bad, we, re, ram_vld, pop;
  logic [1:0]  cnt;
  beat_t       wr_beat, rd_beat, s0, s1;
  assign used        = wr_cur - rd_ptr;
  assign full        = used == {1'b1, {AW{1'b0}}};
  assign bad         = s_rx_tlast & s_rx_tuser;
  assign we          = s_rx_tvalid & (wr_state == WR_PASS) & ~full & ~bad;
  assign wr_beat     = {s_rx_tlast, s_rx_tkeep, s_rx_tdata};
  assign pop         = m_rx_tvalid & m_rx_tready;
  // issue a read only if the output stage plus the in-flight read stays within two entries
  assign re          = (rd_ptr != wr_commit) & ({1'b0, cnt} + {2'b0, ram_vld} < 3'd2 + {2'b0, pop});
  assign m_rx_tvalid = cnt != 2'd0;
  assign {m_rx_tlast, m_rx_tkeep, m_rx_tdata} = s0;
  assign fifo_level  = used + {{(AW-1){1'b0}}, cnt} + {{AW{1'b0}}, ram_vld};
  eth_sdp_ram #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_ram (
    .clk156 (clk156),
    .we     (we),
    .waddr  (wr_cur[AW-1:0]),
    .wdata  (wr_beat),
    .re     (re),
    .raddr  (rd_ptr[AW-1:0]),
    .rdata  (rd_beat)
  );
  always_ff @(posedge clk156)
    if (!sys_rst_n) begin
      wr_state     <= WR_SYNC;
      wr_cur       <= '0;
      wr_commit    <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else if (s_rx_tvalid)
      case (wr_state)
        WR_SYNC, WR_DROP: if (s_rx_tlast) wr_state <= WR_PASS;
        default:
          if (full) begin
            wr_cur       <= wr_commit;
            drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
            if (!s_rx_tlast) wr_state <= WR_DROP;
          end else if (bad) begin
            wr_cur       <= wr_commit;
            drop_err_cnt <= sat_inc(drop_err_cnt);
          end else begin
            wr_cur <= wr_cur + ONE;
            if (s_rx_tlast) wr_commit <= wr_cur + ONE;
          end
      endcase
  always_ff @(posedge clk156)
    if (!sys_rst_n) begin
      rd_ptr  <= '0;
      ram_vld <= 1'b0;
      cnt     <= '0;
      s0      <= '0;
      s1      <= '0;
    end else begin
      if (re) rd_ptr <= rd_ptr + ONE;
      ram_vld <= re;
      cnt     <= cnt + {1'b0, ram_vld} - {1'b0, pop};
      if (ram_vld && cnt - {1'b0, pop} == 2'd0) s0 <= rd_beat;
      else if (pop && cnt == 2'd2) s0 <= s1;
      if (ram_vld && cnt - {1'b0, pop} == 2'd1) s1 <= rd_beat;
    end
endmodule

// File: tb/tb_eth_rx_drop_fifo.sv
// tb_eth_rx_drop_fifo: scoreboard bench for the RX drop FIFO (DEPTH 512 and DEPTH 16 instances)
module tb_eth_rx_drop_fifo;
  logic        clk156 = 1'b0;
  logic        sys_rst_n, rst16_n;
  logic        s_rx_tvalid, s_rx_tlast, s_rx_tuser;
  logic [63:0] s_rx_tdata;
  logic [7:0]  s_rx_tkeep;
  logic        m_rx_tvalid, m_rx_tready, m_rx_tlast;
  logic [63:0] m_rx_tdata;
  logic [7:0]  m_rx_tkeep;
  logic [31:0] drop_err_cnt, drop_ovf_cnt;
  logic [9:0]  fifo_level;
  logic        v16, rdy16, l16;
  logic [63:0] d16;
  logic [7:0]  k16;
  logic [31:0] err16, ovf16;
  logic [4:0]  lvl16;
  logic        rnd_rdy, rdy_fix;
  int          n_cmp, n_err, n_bad, n16;
  logic [72:0] sb [$];
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat;
  logic [72:0] exp_beat;

  always #5 clk156 = ~clk156;

  eth_rx_drop_fifo dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n),
    .s_rx_tvalid(s_rx_tvalid), .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep),
    .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser),
    .m_rx_tvalid(m_rx_tvalid), .m_rx_tready(m_rx_tready), .m_rx_tdata(m_rx_tdata),
    .m_rx_tkeep(m_rx_tkeep), .m_rx_tlast(m_rx_tlast),
    .drop_err_cnt(drop_err_cnt), .drop_ovf_cnt(drop_ovf_cnt), .fifo_level(fifo_level)
  );

  eth_rx_drop_fifo #(.DEPTH(16)) dut16 (
    .clk156(clk156), .sys_rst_n(rst16_n),
    .s_rx_tvalid(s_rx_tvalid), .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep),
    .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser),
    .m_rx_tvalid(v16), .m_rx_tready(rdy16), .m_rx_tdata(d16),
    .m_rx_tkeep(k16), .m_rx_tlast(l16),
    .drop_err_cnt(err16), .drop_ovf_cnt(ovf16), .fifo_level(lvl16)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic send_frame(input int len, input logic [63:0] base, input logic [7:0] last_keep,
                            input logic user, input logic good);
    for (int i = 0; i < len; i++) begin
      s_rx_tvalid = 1'b1;
      s_rx_tdata  = base + 64'(i);
      s_rx_tlast  = i == len - 1;
      s_rx_tkeep  = s_rx_tlast ? last_keep : 8'hFF;
      s_rx_tuser  = s_rx_tlast ? user : 1'b0;
      if (good) sb.push_back({s_rx_tlast, s_rx_tkeep, s_rx_tdata});
      tick(1);
    end
    s_rx_tvalid = 1'b0;
    s_rx_tlast  = 1'b0;
    s_rx_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (sb.size() != 0 || m_rx_tvalid); i++) tick(1);
    chk("drain_left", 80'(sb.size()), 80'(0));
  endtask

  always @(posedge clk156) begin
    #1;
    m_rx_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // output monitor: AXI-Stream hold rules and scoreboard comparison
  always @(negedge clk156) begin
    if (!sys_rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 80'(m_rx_tvalid), 80'(1));
        chk("hold_beat", 80'({m_rx_tlast, m_rx_tkeep, m_rx_tdata}), 80'(prev_beat));
      end
      if (m_rx_tvalid && m_rx_tready) begin
        if (sb.size() == 0) chk("unexpected_beat", 80'(m_rx_tdata), 80'(0));
        else begin
          exp_beat = sb.pop_front();
          chk("tdata", 80'(m_rx_tdata), 80'(exp_beat[63:0]));
          chk("tlast_tkeep", 80'({m_rx_tlast, m_rx_tkeep}), 80'(exp_beat[72:64]));
        end
      end
      prev_stall = m_rx_tvalid && !m_rx_tready;
      prev_beat  = {m_rx_tlast, m_rx_tkeep, m_rx_tdata};
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; n_bad = 0;
    sys_rst_n = 1'b0; rst16_n = 1'b0;
    s_rx_tvalid = 1'b0; s_rx_tdata = '0; s_rx_tkeep = '0; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
    rnd_rdy = 1'b0; rdy_fix = 1'b1; rdy16 = 1'b0;
    tick(3);
    chk("rst_tvalid", 80'(m_rx_tvalid), 80'(0));
    chk("rst_tdata", 80'(m_rx_tdata), 80'(0));
    chk("rst_tlast_tkeep", 80'({m_rx_tlast, m_rx_tkeep}), 80'(0));
    chk("rst_err", 80'(drop_err_cnt), 80'(0));
    chk("rst_ovf", 80'(drop_ovf_cnt), 80'(0));
    chk("rst_level", 80'(fifo_level), 80'(0));
    sys_rst_n = 1'b1;
    // first tlast after reset only synchronises the write side
    send_frame(1, 64'hDEAD, 8'hFF, 1'b0, 1'b0);
    send_frame(8, 64'h0, 8'h0F, 1'b0, 1'b1);
    tick(1);
    chk("lat_commit_p1", 80'(m_rx_tvalid), 80'(0));
    tick(1);
    chk("lat_commit_p2", 80'(m_rx_tvalid), 80'(1));
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("b2b_valid", 80'(m_rx_tvalid), 80'(1));
    end
    wait_drain(200);
    send_frame(6, 64'h100, 8'hFF, 1'b1, 1'b0);
    send_frame(2, 64'h200, 8'h03, 1'b0, 1'b1);
    wait_drain(200);
    chk("err_cnt_one", 80'(drop_err_cnt), 80'(1));
    chk("ovf_cnt_zero", 80'(drop_ovf_cnt), 80'(0));
    // buffer a frame behind a stalled sink, then reset mid-frame
    rdy_fix = 1'b0;
    tick(2);
    send_frame(5, 64'h300, 8'hFF, 1'b0, 1'b0);
    tick(6);
    chk("stall_valid", 80'(m_rx_tvalid), 80'(1));
    chk("stall_level", 80'(fifo_level), 80'(5));
    sys_rst_n = 1'b0;
    s_rx_tvalid = 1'b1; s_rx_tdata = 64'h400; s_rx_tkeep = 8'hFF;
    tick(1);
    chk("rst2_tvalid", 80'(m_rx_tvalid), 80'(0));
    chk("rst2_tdata", 80'(m_rx_tdata), 80'(0));
    chk("rst2_tlast_tkeep", 80'({m_rx_tlast, m_rx_tkeep}), 80'(0));
    chk("rst2_err", 80'(drop_err_cnt), 80'(0));
    chk("rst2_level", 80'(fifo_level), 80'(0));
    sys_rst_n = 1'b1;
    send_frame(4, 64'h401, 8'hFF, 1'b0, 1'b0);
    rdy_fix = 1'b1;
    tick(10);
    chk("midframe_no_out", 80'(m_rx_tvalid), 80'(0));
    chk("midframe_level", 80'(fifo_level), 80'(0));
    chk("midframe_cnts", 80'({drop_err_cnt, drop_ovf_cnt}), 80'(0));
    send_frame(4, 64'h500, 8'h7F, 1'b0, 1'b1);
    wait_drain(200);
    // DEPTH=16: exact-fit frame accepted, following frame overflows
    rst16_n = 1'b1;
    send_frame(1, 64'h1500, 8'hFF, 1'b0, 1'b1);
    send_frame(16, 64'h1600, 8'hFF, 1'b0, 1'b1);
    send_frame(4, 64'h1700, 8'hFF, 1'b0, 1'b1);
    tick(10);
    chk("d16_ovf", 80'(ovf16), 80'(1));
    chk("d16_err", 80'(err16), 80'(0));
    chk("d16_level", 80'(lvl16), 80'(16));
    chk("d16_valid", 80'(v16), 80'(1));
    rdy16 = 1'b1;
    n16 = 0;
    repeat (40) begin
      @(negedge clk156);
      if (v16 && rdy16) begin
        chk("d16_data", 80'(d16), 80'(64'h1600 + 64'(n16)));
        chk("d16_last", 80'(l16), 80'(n16 == 15));
        n16++;
      end
    end
    tick(1);
    chk("d16_beats", 80'(n16), 80'(16));
    wait_drain(200);
    // random sink, random frames, paced so the 512-entry buffer never overflows
    rnd_rdy = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int  len;
      logic bad;
      for (int i = 0; i < 3000 && fifo_level > 10'd440; i++) tick(1);
      if (fifo_level > 10'd440) chk("pace_timeout", 80'(fifo_level), 80'(440));
      len = $urandom_range(1, 64);
      bad = $urandom_range(0, 9) == 0;
      if (bad) n_bad++;
      send_frame(len, {$urandom, $urandom}, 8'($urandom_range(1, 255)), bad, !bad);
    end
    wait_drain(5000);
    chk("rand_err_cnt", 80'(drop_err_cnt), 80'(n_bad));
    chk("rand_ovf_cnt", 80'(drop_ovf_cnt), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/eth_rx_drop_fifo.md
ETH_RX_DROP_FIFO -- requirements
Module: eth_rx_drop_fifo

Interface
REQ-001 Parameter DEPTH, default 512, storage depth in 64-bit beats; power of two, 16..4096.
REQ-002 clk156  in  1  core clock (MAC coreclk), sole clock of the block.
REQ-003 sys_rst_n  in  1  synchronous, active-low reset.
REQ-004 s_rx_tvalid  in  1  beat valid from MAC RX stream; no backpressure exists.
REQ-005 s_rx_tdata  in  64  beat data.
REQ-006 s_rx_tkeep  in  8  byte enables.
REQ-007 s_rx_tlast  in  1  last beat of frame.
REQ-008 s_rx_tuser  in  1  frame bad (FCS/length error), meaningful on tlast beat.
REQ-009 m_rx_tvalid  out  1  output beat valid.
REQ-010 m_rx_tready  in  1  downstream ready.
REQ-011 m_rx_tdata  out  64 / m_rx_tkeep  out  8 / m_rx_tlast  out  1  output beat fields.
REQ-012 drop_err_cnt  out  32  frames dropped for tuser=1.
REQ-013 drop_ovf_cnt  out  32  frames dropped for buffer overflow.
REQ-014 fifo_level  out  log2(DEPTH)+1  committed-plus-pending occupancy in beats.

Function
REQ-015 Block SHALL be store-and-forward: no beat of a frame appears on m_rx before its tlast beat is accepted and committed.
REQ-016 Storage: circular buffer of DEPTH entries {tdata,tkeep,tlast}; pointers rd_ptr, wr_cur, wr_commit, each log2(DEPTH)+1 bits with wrap bit.
REQ-017 Write FSM states: WR_SYNC, WR_PASS, WR_DROP; reset state WR_SYNC.
REQ-018 WR_SYNC: discard all beats; on accepted tlast beat -> WR_PASS; no counter increments.
REQ-019 WR_PASS: each valid beat written at wr_cur, wr_cur increments.
REQ-020 WR_PASS tlast beat with tuser=0 and space: beat written, wr_commit <= wr_cur+1 in same cycle.
REQ-021 WR_PASS tlast beat with tuser=1: beat discarded, wr_cur <= wr_commit, drop_err_cnt increments.
REQ-022 Full when wr_cur - rd_ptr == DEPTH; a valid beat arriving while full -> beat discarded, wr_cur <= wr_commit; if that beat has tlast stay WR_PASS, else -> WR_DROP; drop_ovf_cnt increments once per frame.
REQ-023 WR_DROP: discard beats; on tlast -> WR_PASS; no further counter change.
REQ-024 A frame filling exactly DEPTH beats with space for every beat SHALL be accepted.
REQ-025 Overflow and error on same tlast beat SHALL count as overflow only.
REQ-026 Counters saturate at 0xFFFF_FFFF.
REQ-027 Read side: frames readable while rd_ptr != wr_commit; RAM read registered; output held in a 2-entry output stage so m_rx_tvalid is continuous across back-to-back committed beats with m_rx_tready=1.
REQ-028 With buffer and output stage empty, m_rx_tvalid SHALL assert exactly 2 cycles after the commit cycle.
REQ-029 AXI-Stream rules: m_rx_tdata/tkeep/tlast stable while m_rx_tvalid=1 and m_rx_tready=0; m_rx_tvalid never deasserts without a transfer.
REQ-030 rd_ptr increments on RAM read issue; freed space visible to write side the following cycle.
REQ-031 Simultaneous commit and read SHALL both take effect; simultaneous rollback and read SHALL not disturb rd_ptr.
REQ-032 tkeep passed unchanged; no tkeep validation.

Reset
REQ-033 While sys_rst_n=0 at clk156 edge: all pointers 0, FSM WR_SYNC, output stage empty, m_rx_tvalid=0, m_rx_tdata/tkeep/tlast=0, counters 0, fifo_level=0.
REQ-034 Reset mid-frame on either side discards all buffered data; no partial frame emitted afterwards.
REQ-035 RAM contents need not be reset.

Structure
REQ-036 Shared package eth_pkg holds ETH_DATA_W=64, ETH_KEEP_W=8 and the write-FSM state enum.
REQ-037 One sub-module eth_sdp_ram: simple dual-port RAM, one write port, one registered read port, same clock, parameterised width/depth.

Verification
REQ-038 Reset release mid-frame: 3 beats then tlast tuser=0 -> nothing output, counters 0; next 4-beat frame output intact.
REQ-039 8-beat frame data 0..7, tkeep 0xFF, last tkeep 0x0F, tuser=0, m_rx_tready=1 -> m_rx_tvalid 2 cycles after tlast, 8 consecutive beats, identical data.
REQ-040 6-beat frame tuser=1 on tlast followed by 2-beat good frame -> only 2-beat frame output, drop_err_cnt=1.
REQ-041 DEPTH=16, m_rx_tready=0, 16-beat frame then 4-beat frame -> first accepted, second dropped, drop_ovf_cnt=1, fifo_level=16; ready=1 -> exactly 16 beats out.
REQ-042 Random m_rx_tready (50%), 1000 frames of 1..64 beats, 10% tuser=1 -> output equals good-frame model, no AXIS rule violation, drop_err_cnt matches.
